// File: rtl/boton_mantenimiento_debounce.sv
// Maintenance button conditioner: 2-FF sync + debounce FSM; press pulse after D+2 edges, long-press after LONG more.
// Pure pulse/level outputs, no backpressure; habilitar=0 parks the FSM idle while the sync chain keeps running.
`timescale 1ns/1ps
module boton_mantenimiento_debounce #(
    parameter int DEBOUNCE_CYCLES   = 16,
    parameter int LONG_PRESS_CYCLES = 1000
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       boton_raw,
    input  logic       habilitar,
    output logic       mantenimiento,
    output logic       presionado,
    output logic       pulsacion_larga,
    output logic [7:0] rebotes
);

    localparam int CW = (LONG_PRESS_CYCLES > 1) ? $clog2(LONG_PRESS_CYCLES) : 1;
    localparam int DW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_DEB_LAST  = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [CW-1:0] CNT_LONG_LAST = CW'(LONG_PRESS_CYCLES - 1);
    localparam logic [DW-1:0] DCNT_LAST     = DW'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        SUELTO,
        CONFIRMA_PRESION,
        PRESIONADO,
        CONFIRMA_LIBERACION
    } estado_t;

    estado_t       estado_q, estado_d;
    logic          s1_q, s1_d, s2_q, s2_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [DW-1:0] dcnt_q, dcnt_d;
    logic          flag_q, flag_d;
    logic [7:0]    rebotes_q, rebotes_d, rebotes_inc;
    logic          mant_q, mant_d;
    logic          larga_q, larga_d;
    logic          pres_q, pres_d;

    assign s1_d        = boton_raw;
    assign s2_d        = s1_q;
    assign rebotes_inc = (rebotes_q == 8'hFF) ? rebotes_q : rebotes_q + 8'd1;

    always_comb begin
        estado_d  = estado_q;
        cnt_d     = cnt_q;
        dcnt_d    = dcnt_q;
        flag_d    = flag_q;
        rebotes_d = rebotes_q;
        mant_d    = 1'b0;
        larga_d   = 1'b0;
        if (!habilitar) begin
            estado_d = SUELTO;
            cnt_d    = '0;
            dcnt_d   = '0;
            flag_d   = 1'b0;
        end else begin
            case (estado_q)
                SUELTO: begin
                    if (s2_q) begin
                        estado_d = CONFIRMA_PRESION;
                        cnt_d    = '0;
                    end
                end
                CONFIRMA_PRESION: begin
                    if (!s2_q) begin
                        estado_d  = SUELTO;
                        rebotes_d = rebotes_inc;
                    end else if (cnt_q == CNT_DEB_LAST) begin
                        estado_d = PRESIONADO;
                        cnt_d    = '0;
                        mant_d   = 1'b1;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                PRESIONADO: begin
                    // cnt keeps the held time across a rejected release bounce
                    if (!s2_q) begin
                        estado_d = CONFIRMA_LIBERACION;
                        dcnt_d   = '0;
                    end else if (cnt_q == CNT_LONG_LAST && !flag_q) begin
                        larga_d = 1'b1;
                        flag_d  = 1'b1;
                    end else if (cnt_q != CNT_LONG_LAST) begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                CONFIRMA_LIBERACION: begin
                    if (s2_q) begin
                        estado_d  = PRESIONADO;
                        rebotes_d = rebotes_inc;
                    end else if (dcnt_q == DCNT_LAST) begin
                        estado_d = SUELTO;
                        flag_d   = 1'b0;
                    end else begin
                        dcnt_d = dcnt_q + 1'b1;
                    end
                end
                default: estado_d = SUELTO;
            endcase
        end
        pres_d = (estado_d == PRESIONADO) || (estado_d == CONFIRMA_LIBERACION);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1_q      <= 1'b0;
            s2_q      <= 1'b0;
            estado_q  <= SUELTO;
            cnt_q     <= '0;
            dcnt_q    <= '0;
            flag_q    <= 1'b0;
            rebotes_q <= 8'd0;
            mant_q    <= 1'b0;
            larga_q   <= 1'b0;
            pres_q    <= 1'b0;
        end else begin
            s1_q      <= s1_d;
            s2_q      <= s2_d;
            estado_q  <= estado_d;
            cnt_q     <= cnt_d;
            dcnt_q    <= dcnt_d;
            flag_q    <= flag_d;
            rebotes_q <= rebotes_d;
            mant_q    <= mant_d;
            larga_q   <= larga_d;
            pres_q    <= pres_d;
        end
    end

    assign mantenimiento   = mant_q;
    assign pulsacion_larga = larga_q;
    assign presionado      = pres_q;
    assign rebotes         = rebotes_q;

endmodule

// File: doc/boton_mantenimiento_debounce.md
Name: boton_mantenimiento_debounce

Overview:
- Upstream conditioning stage for the maintenance push button.
- Synchronises the raw asynchronous button and debounces it with a four-state FSM.
- Emits the clean single-cycle `mantenimiento` pulse consumed by the maintenance FSM, plus a debounced level, a long-press pulse and a saturating glitch counter for diagnostics.

Parameters:
- DEBOUNCE_CYCLES, 16, consecutive stable synchronised samples required to accept a press or release; legal range >= 2.
- LONG_PRESS_CYCLES, 1000, cycles in PRESIONADO before `pulsacion_larga` fires; must be > DEBOUNCE_CYCLES.

Ports:
- clk  input  1  system clock, all logic on rising edge
- reset_n  input  1  asynchronous, active-low reset
- boton_raw  input  1  raw push button, asynchronous to clk, bouncing
- habilitar  input  1  enable; 0 forces block idle
- mantenimiento  output  1  one-cycle pulse per accepted press
- presionado  output  1  debounced button level
- pulsacion_larga  output  1  one-cycle pulse, at most once per press
- rebotes  output  8  count of rejected glitches, saturating at 255

Behaviour:
- Reset (reset_n=0, asynchronous, takes effect immediately, including mid-press or mid-pulse):
  - both sync FFs = 0, state = SUELTO, counters = 0, long-press flag = 0
  - all outputs = 0; an in-flight pulse drops at once
- Synchroniser: 2-FF chain boton_raw -> s1 -> s2; the FSM sees only s2.
- Counter: cnt is sized to hold LONG_PRESS_CYCLES-1.
- States and transitions (evaluated each clock edge while habilitar=1):
  - SUELTO:
    - s2=1 -> CONFIRMA_PRESION, cnt <= 0
  - CONFIRMA_PRESION:
    - s2=0 -> SUELTO, rebotes++
    - s2=1 and cnt == DEBOUNCE_CYCLES-1 -> PRESIONADO, cnt <= 0; `mantenimiento` = 1 for exactly that next cycle
    - otherwise cnt++
  - PRESIONADO:
    - s2=0 -> CONFIRMA_LIBERACION, dcnt <= 0 (separate debounce counter; cnt holds)
    - else if cnt == LONG_PRESS_CYCLES-1 and flag=0 -> `pulsacion_larga` = 1 for one cycle, flag <= 1
    - else cnt++, saturating at LONG_PRESS_CYCLES-1
  - CONFIRMA_LIBERACION:
    - s2=1 -> PRESIONADO, rebotes++; cnt keeps its value, no new `mantenimiento`
    - s2=0 and dcnt == DEBOUNCE_CYCLES-1 -> SUELTO, flag <= 0
    - otherwise dcnt++
    - cnt does not advance in this state
- presionado = 1 in PRESIONADO and CONFIRMA_LIBERACION, else 0. It is registered and rises in the same cycle as `mantenimiento`.
- Latency: if boton_raw is first sampled high at edge 0 and stays high, `mantenimiento` is high in the cycle after edge DEBOUNCE_CYCLES+2 (D=16 -> after edge 18). Release latency is symmetric: presionado falls after edge D+2 from the first sampled low.
- `mantenimiento` and `pulsacion_larga` are registered. They never assert in the same cycle, since LONG_PRESS_CYCLES > DEBOUNCE_CYCLES.
- rebotes: increments by 1 per rejected glitch, holds at 255 (no wrap), cleared only by reset.
- habilitar=0 (synchronous):
  - next state SUELTO; cnt, dcnt and flag cleared; pulses suppressed
  - presionado = 0 from the next cycle
  - rebotes holds; the sync chain keeps running
- habilitar 0->1 with the button held: s2=1 in SUELTO restarts full confirmation; exactly one `mantenimiento` after D+1 more cycles.
- A glitch shorter than D cycles never produces `mantenimiento` or changes presionado.

Test Plan (sim parameters D=4, LONG=20):
- Reset: reset_n=0 with boton_raw=1 -> all outputs 0 during reset; release reset, hold raw=1 -> one `mantenimiento` pulse, 1 cycle wide, D+2=6 edges after first sampled high; presionado=1 thereafter.
- Bounce on press: raw toggles 1,0,1,0 on single cycles, then held -> rebotes=2, exactly one `mantenimiento`, no pulse during bounce.
- Bounce on release: while PRESIONADO, raw 0 for 2 cycles then 1 -> presionado stays 1, rebotes+1, no second `mantenimiento`; then raw 0 held -> presionado falls 6 edges after first sampled low.
- Long press: hold raw=1 for 40 cycles after acceptance -> exactly one `pulsacion_larga`, 20 cycles after `mantenimiento`; none repeated; release and press again -> fires again.
- Saturation: 300 single-cycle glitches -> rebotes=255 and stays 255.
- Enable and async reset: habilitar=0 mid-CONFIRMA_PRESION -> no pulse, presionado 0; habilitar=1 with raw held -> one pulse 5 cycles later. reset_n low for part of a cycle during the pulse -> `mantenimiento` drops immediately.
